// File: rtl/mult_arbiter_pkg.sv
// Shared helpers for the multiplier arbiter: id-width sizing and defaults.
package mult_arbiter_pkg;

  localparam int DEF_D_W   = 8;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_LAT   = 3;

  // Bits needed to name one of n requesters; never less than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_arbiter_rr.sv
// Round-robin search: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx[ID_W-1:0]]) begin
        grant_id  = idx[ID_W-1:0];
        grant_vld = 1'b1;
      end
    end
    if (grant_vld) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier among N_REQ requesters; a tag pipeline that
// tracks the multiplier latency routes each product back to its originator.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int D_W    = DEF_D_W,
  parameter int N_REQ  = DEF_N_REQ,
  parameter int LAT    = DEF_LAT,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*D_W-1:0]     req_a,
  input  logic [N_REQ*D_W-1:0]     req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [D_W-1:0]           mult_a,
  output logic [D_W-1:0]           mult_b,
  input  logic [2*D_W-1:0]         mult_out,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [2*D_W-1:0]         resp_data,
  output logic [$clog2(LAT+1)-1:0] inflight,
  output logic                     busy
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(LAT+1);

  // SIGNED only selects the external multiplier mode; operands here are opaque bits.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]  ptr_reg;
  logic [CNT_W-1:0] inflight_reg;
  tag_t             tag_reg [LAT];
  tag_t             last_tag;

  logic [N_REQ-1:0] req_masked;
  logic [ID_W-1:0]  grant_id;
  logic             transfer;

  // Nothing is offered for arbitration while disabled or held in reset.
  assign req_masked = req_valid & {N_REQ{en & rst}};

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req       (req_masked),
    .ptr       (ptr_reg),
    .grant     (req_ready),
    .grant_id  (grant_id),
    .grant_vld (transfer)
  );

  // Steer the granted operand pair to the multiplier; idle cycles present zeros.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    if (transfer) begin
      mult_a = req_a[grant_id*D_W +: D_W];
      mult_b = req_b[grant_id*D_W +: D_W];
    end
  end

  // Pointer moves just past the requester that was served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr_reg <= '0;
    else if (transfer)
      ptr_reg <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Stage 0 captures who was granted this cycle (vld=0 marks a bubble).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tag_reg[0] <= '0;
    else      tag_reg[0] <= '{vld: transfer, id: grant_id};
  end

  // Remaining stages delay the tag in lock-step with the multiplier pipeline.
  for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) tag_reg[gi] <= '0;
      else      tag_reg[gi] <= tag_reg[gi-1];
    end
  end

  assign last_tag = tag_reg[LAT-1];

  // The last stage lines up with the product currently on mult_out.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_resp
    assign resp_valid[gi] = last_tag.vld && (last_tag.id == ID_W'(gi));
  end
  assign resp_data = last_tag.vld ? mult_out : '0;

  // Outstanding-op count: issue adds one, retire removes one, both cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      inflight_reg <= '0;
    else if (transfer && !last_tag.vld)
      inflight_reg <= inflight_reg + 1'b1;
    else if (!transfer && last_tag.vld)
      inflight_reg <= inflight_reg - 1'b1;
  end

  assign inflight = inflight_reg;
  assign busy     = (inflight_reg != '0);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier and scoreboard.
module tb_mult_arbiter;

  localparam int D_W = 8;
  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int RB  = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en  = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*D_W-1:0] req_a = '0;
  logic [N*D_W-1:0] req_b = '0;
  logic [N-1:0]     req_ready;
  logic [D_W-1:0]   mult_a, mult_b;
  logic [2*D_W-1:0] mult_out;
  logic [N-1:0]     resp_valid;
  logic [2*D_W-1:0] resp_data;
  logic [1:0]       inflight;
  logic             busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.D_W(D_W), .N_REQ(N), .LAT(LAT), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mult_a(mult_a), .mult_b(mult_b), .mult_out(mult_out),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .inflight(inflight), .busy(busy)
  );

  // Stand-in for optmult: LAT-deep product pipeline, mode chosen by the bench.
  bit signed_mode = 1'b0;
  logic [2*D_W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    logic signed [2*D_W-1:0] sp;
    sp = $signed(mult_a) * $signed(mult_b);
    mpipe[0] <= signed_mode ? sp : {8'h00, mult_a} * {8'h00, mult_b};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mult_out = mpipe[LAT-1];

  // Reference model state: rotating pointer and a time-indexed response schedule.
  int           ptr = 0;
  int           cyc = 0;
  logic [N-1:0] exp_rv [RB];
  logic [15:0]  exp_rd [RB];
  bit           iss    [RB];

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input bit sm);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (sm) begin
      if (sa >= 128) sa = sa - 256;
      if (sb >= 128) sb = sb - 256;
    end
    return 16'(sa * sb);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*D_W +: D_W] = a;
    req_b[i*D_W +: D_W] = b;
  endtask

  // Called at a negedge with inputs already set: checks this cycle, then advances the model.
  task automatic step();
    int g, s, t, inf;
    logic [N-1:0]   er;
    logic [D_W-1:0] ea, eb;
    if (!rst) begin
      ptr = 0;
      for (int i = 0; i < RB; i++) begin
        exp_rv[i] = '0; exp_rd[i] = '0; iss[i] = 1'b0;
      end
    end
    #1;
    g = -1;
    if (rst && en)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    er = '0; ea = '0; eb = '0;
    if (g >= 0) begin
      er[g] = 1'b1;
      ea = req_a[g*D_W +: D_W];
      eb = req_b[g*D_W +: D_W];
    end
    s = cyc % RB;
    inf = 0;
    for (int k = 1; k <= LAT; k++) if (iss[(cyc + RB - k) % RB]) inf++;
    $display("[TB] cyc=%0d rst=%0b en=%0b valid=%b ready=%b a=%0h b=%0h resp=%b data=%0h inflight=%0d",
             cyc, rst, en, req_valid, req_ready, mult_a, mult_b, resp_valid, resp_data, inflight);
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("mult_a", 32'(mult_a), 32'(ea));
    chk("mult_b", 32'(mult_b), 32'(eb));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv[s]));
    chk("resp_data", 32'(resp_data), 32'(exp_rd[s]));
    chk("inflight", 32'(inflight), 32'(inf));
    chk("busy", 32'(busy), 32'(inf != 0));
    @(posedge clk);
    exp_rv[s] = '0;
    exp_rd[s] = '0;
    iss[s] = (g >= 0);
    if (g >= 0) begin
      ptr = (g + 1) % N;
      t = (cyc + LAT) % RB;
      exp_rv[t] = er;
      exp_rd[t] = ref_prod(ea, eb, signed_mode);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < RB; i++) begin
      exp_rv[i] = '0; exp_rd[i] = '0; iss[i] = 1'b0;
    end
    @(negedge clk);
    // Held in reset: everything reads zero even with requests pending.
    en = 1'b1; req_valid = 4'b1111;
    step();
    step();
    rst = 1'b1;
    idle(1);

    // Single request from 0: 7*9 returns after LAT cycles.
    set_req(0, 8'd7, 8'd9);
    req_valid = 4'b0001;
    step();
    idle(4);

    // All valid for 8 cycles: grants rotate 0..3 twice, responses follow in order.
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 1), 8'(10 + i));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    idle(4);

    // Full-scale unsigned product from requester 2.
    set_req(2, 8'd255, 8'd255);
    req_valid = 4'b0100;
    step();
    idle(4);

    // Signed multiplier mode: -3 * 5 = 16'hFFF1.
    signed_mode = 1'b1;
    set_req(1, 8'hFD, 8'd5);
    req_valid = 4'b0010;
    step();
    idle(4);
    signed_mode = 1'b0;

    // Issue every cycle, then drop en: grants stop at once, pipeline drains.
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    en = 1'b1;

    // Steer pointer to 2 via requester 1, then only 1 and 3 valid: grant 3 then 1.
    idle(1);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b1010;
    step();
    step();
    idle(4);

    // Reset with ops in flight: outputs clear at once and nothing stale returns.
    req_valid = 4'b1111;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle(6);

    // Randomised traffic, including signed mode, en toggling and occasional resets.
    for (int n = 0; n < 300; n++) begin
      req_valid   = 4'($urandom);
      req_a       = 32'($urandom);
      req_b       = 32'($urandom);
      en          = ($urandom_range(0, 7) != 0);
      rst         = ($urandom_range(0, 59) != 0);
      signed_mode = 1'($urandom);
      step();
    end
    rst = 1'b1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
